// File: rtl/shifter_regfile.sv
// shifter_regfile
//   Back end of the MIC-1 datapath. The ALU result is shifted onto the C bus,
//   the ALU N/Z flags are latched, the selected registers are written, and
//   H / the chosen B source are driven back into the ALU. The block also owns
//   the two memory ports: a word port (MAR/MDR) and a byte fetch port (PC/MBR).
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   alu_y, alu_n, alu_z   ALU result and flags
//   shift                 00 none, 01 arithmetic right by 1, 10 left by 8, 11 none
//   c_sel                 write enables {H,OPC,TOS,CPP,LV,SP,PC,MDR,MAR}
//   b_sel                 B bus source (0 MDR .. 8 OPC, 9-15 zero)
//   rd, wr, fetch         memory request pulses
//   a_bus, b_bus          ALU operand buses
//   n_flag, z_flag        registered ALU flags
//   busy                  any memory transaction outstanding
//   mem_*                 word port (byte address, write enable, write data, ack, read data)
//   ftc_*                 byte fetch port (address, ack, read data)

module shifter_regfile #(
  parameter int               NBITS   = 32,
  parameter logic [NBITS-1:0] SP_RST  = '0,
  parameter logic [NBITS-1:0] LV_RST  = '0,
  parameter logic [NBITS-1:0] CPP_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] alu_y,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic [1:0]       shift,
  input  logic [8:0]       c_sel,
  input  logic [3:0]       b_sel,
  input  logic             rd,
  input  logic             wr,
  input  logic             fetch,
  output logic [NBITS-1:0] a_bus,
  output logic [NBITS-1:0] b_bus,
  output logic             n_flag,
  output logic             z_flag,
  output logic             busy,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [NBITS-1:0] mem_rdata,
  output logic             ftc_req,
  output logic [NBITS-1:0] ftc_addr,
  input  logic             ftc_ack,
  input  logic [7:0]       ftc_rdata
);

  typedef enum logic {IDLE, PEND} port_state_t;

  port_state_t      word_state, fetch_state;
  logic [NBITS-1:0] c_bus;
  logic [NBITS-1:0] h, opc, tos, cpp, lv, sp, pc, mdr, mar;
  logic [7:0]       mbr;
  logic             rd_done;

  always_comb begin
    case (shift)
      2'b01:   c_bus = {alu_y[NBITS-1], alu_y[NBITS-1:1]};
      2'b10:   c_bus = {alu_y[NBITS-9:0], 8'h00};
      default: c_bus = alu_y;
    endcase
  end

  // A completed read owns MDR on its ack edge, even if C also targets MDR.
  assign rd_done = (word_state == PEND) && mem_ack && !mem_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h      <= '0;
      opc    <= '0;
      tos    <= '0;
      cpp    <= CPP_RST;
      lv     <= LV_RST;
      sp     <= SP_RST;
      pc     <= '0;
      mdr    <= '0;
      mar    <= '0;
      n_flag <= 1'b0;
      z_flag <= 1'b1;
    end else begin
      n_flag <= alu_n;
      z_flag <= alu_z;
      if (c_sel[8]) h   <= c_bus;
      if (c_sel[7]) opc <= c_bus;
      if (c_sel[6]) tos <= c_bus;
      if (c_sel[5]) cpp <= c_bus;
      if (c_sel[4]) lv  <= c_bus;
      if (c_sel[3]) sp  <= c_bus;
      if (c_sel[2]) pc  <= c_bus;
      if (rd_done)       mdr <= mem_rdata;
      else if (c_sel[1]) mdr <= c_bus;
      if (c_sel[0]) mar <= c_bus;
    end
  end

  // Word port: address, direction and data are captured at the request edge
  // so they stay stable while the request is pending. MAR holds a word index,
  // hence the shift to a byte address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_state <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (word_state)
        IDLE: begin
          if (rd || wr) begin
            word_state <= PEND;
            mem_req    <= 1'b1;
            mem_we     <= wr;
            mem_addr   <= mar << 2;
            mem_wdata  <= mdr;
          end
        end
        PEND: begin
          if (mem_ack) begin
            word_state <= IDLE;
            mem_req    <= 1'b0;
          end
        end
      endcase
    end
  end

  // Fetch port runs independently of the word port and may overlap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_state <= IDLE;
      ftc_req     <= 1'b0;
      ftc_addr    <= '0;
      mbr         <= '0;
    end else begin
      case (fetch_state)
        IDLE: begin
          if (fetch) begin
            fetch_state <= PEND;
            ftc_req     <= 1'b1;
            ftc_addr    <= pc;
          end
        end
        PEND: begin
          if (ftc_ack) begin
            fetch_state <= IDLE;
            ftc_req     <= 1'b0;
            mbr         <= ftc_rdata;
          end
        end
      endcase
    end
  end

  assign busy  = mem_req | ftc_req;
  assign a_bus = h;

  always_comb begin
    case (b_sel)
      4'd0:    b_bus = mdr;
      4'd1:    b_bus = pc;
      4'd2:    b_bus = {{(NBITS-8){mbr[7]}}, mbr};
      4'd3:    b_bus = {{(NBITS-8){1'b0}}, mbr};
      4'd4:    b_bus = sp;
      4'd5:    b_bus = lv;
      4'd6:    b_bus = cpp;
      4'd7:    b_bus = tos;
      4'd8:    b_bus = opc;
      default: b_bus = '0;
    endcase
  end

endmodule

// File: tb/tb_shifter_regfile.sv
// tb_shifter_regfile
//   Self-checking bench for shifter_regfile: a register-array model of the
//   datapath is compared against the DUT every cycle, with directed scenarios
//   pinned by literal expectations followed by randomized traffic.

module tb_shifter_regfile;

  localparam logic [31:0] SP_R  = 32'h0000_0100;
  localparam logic [31:0] LV_R  = 32'h0000_0200;
  localparam logic [31:0] CPP_R = 32'h0000_0300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_y;
  logic        alu_n, alu_z;
  logic [1:0]  shift;
  logic [8:0]  c_sel;
  logic [3:0]  b_sel;
  logic        rd, wr, fetch;
  logic [31:0] a_bus, b_bus;
  logic        n_flag, z_flag, busy;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ftc_req;
  logic [31:0] ftc_addr;
  logic        ftc_ack;
  logic [7:0]  ftc_rdata;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state: m_r indexed like c_sel bits (0 MAR,1 MDR,2 PC,3 SP,4 LV,5 CPP,6 TOS,7 OPC,8 H)
  logic [31:0] m_r [9];
  logic [7:0]  m_mbr;
  logic        m_n, m_z;
  logic        m_wpend, m_we, m_fpend;
  logic [31:0] m_waddr, m_wdata, m_faddr;

  logic [3:0] all_sels [7] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

  always #5 clk = ~clk;

  shifter_regfile #(
    .NBITS  (32),
    .SP_RST (SP_R),
    .LV_RST (LV_R),
    .CPP_RST(CPP_R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_y    (alu_y),
    .alu_n    (alu_n),
    .alu_z    (alu_z),
    .shift    (shift),
    .c_sel    (c_sel),
    .b_sel    (b_sel),
    .rd       (rd),
    .wr       (wr),
    .fetch    (fetch),
    .a_bus    (a_bus),
    .b_bus    (b_bus),
    .n_flag   (n_flag),
    .z_flag   (z_flag),
    .busy     (busy),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .ftc_req  (ftc_req),
    .ftc_addr (ftc_addr),
    .ftc_ack  (ftc_ack),
    .ftc_rdata(ftc_rdata)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] shifted(input logic [31:0] y, input logic [1:0] s);
    logic signed [31:0] sy;
    sy = y;
    if (s == 2'd1) return sy >>> 1;
    if (s == 2'd2) return y << 8;
    return y;
  endfunction

  function automatic logic [31:0] expect_b(input logic [3:0] sel);
    logic signed [7:0] smbr;
    smbr = m_mbr;
    case (sel)
      4'd0:    return m_r[1];
      4'd1:    return m_r[2];
      4'd2:    return 32'(smbr);
      4'd3:    return 32'(m_mbr);
      4'd4:    return m_r[3];
      4'd5:    return m_r[4];
      4'd6:    return m_r[5];
      4'd7:    return m_r[6];
      4'd8:    return m_r[7];
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: registers load C, memory data overrides MDR on a read completion.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) m_r[i] <= 32'd0;
      m_r[3]  <= SP_R;
      m_r[4]  <= LV_R;
      m_r[5]  <= CPP_R;
      m_mbr   <= 8'd0;
      m_n     <= 1'b0;
      m_z     <= 1'b1;
      m_wpend <= 1'b0;
      m_fpend <= 1'b0;
      m_we    <= 1'b0;
      m_waddr <= 32'd0;
      m_wdata <= 32'd0;
      m_faddr <= 32'd0;
    end else begin
      for (int i = 0; i < 9; i++)
        if (c_sel[i]) m_r[i] <= shifted(alu_y, shift);
      m_n <= alu_n;
      m_z <= alu_z;
      if (m_wpend) begin
        if (mem_ack) begin
          m_wpend <= 1'b0;
          if (!m_we) m_r[1] <= mem_rdata;
        end
      end else if (rd || wr) begin
        m_wpend <= 1'b1;
        m_we    <= wr;
        m_waddr <= m_r[0] * 4;
        m_wdata <= m_r[1];
      end
      if (m_fpend) begin
        if (ftc_ack) begin
          m_fpend <= 1'b0;
          m_mbr   <= ftc_rdata;
        end
      end else if (fetch) begin
        m_fpend <= 1'b1;
        m_faddr <= m_r[2];
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("a_bus", a_bus, m_r[8]);
      check_output("b_bus", b_bus, expect_b(b_sel));
      check_output("n_flag", 32'(n_flag), 32'(m_n));
      check_output("z_flag", 32'(z_flag), 32'(m_z));
      check_output("busy", 32'(busy), 32'(m_wpend | m_fpend));
      check_output("mem_req", 32'(mem_req), 32'(m_wpend));
      check_output("ftc_req", 32'(ftc_req), 32'(m_fpend));
      if (m_wpend) begin
        check_output("mem_addr", mem_addr, m_waddr);
        check_output("mem_we", 32'(mem_we), 32'(m_we));
        check_output("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_fpend) check_output("ftc_addr", ftc_addr, m_faddr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_y = 32'd0; alu_n = 1'b0; alu_z = 1'b1; shift = 2'd0;
    c_sel = 9'd0; b_sel = 4'd0; rd = 1'b0; wr = 1'b0; fetch = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'd0; ftc_ack = 1'b0; ftc_rdata = 8'd0;
  endtask

  task automatic apply_stimulus();
    alu_y     = $urandom;
    alu_n     = 1'($urandom_range(0, 1));
    alu_z     = 1'($urandom_range(0, 1));
    shift     = 2'($urandom_range(0, 3));
    c_sel     = 9'($urandom) & 9'($urandom);
    b_sel     = 4'($urandom_range(0, 15));
    rd        = ($urandom_range(0, 3) == 0);
    wr        = ($urandom_range(0, 5) == 0);
    fetch     = ($urandom_range(0, 3) == 0);
    mem_ack   = ($urandom_range(0, 2) == 0);
    mem_rdata = $urandom;
    ftc_ack   = ($urandom_range(0, 2) == 0);
    ftc_rdata = 8'($urandom);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_a_bus", a_bus, 32'h0);
    check_output("rst_b_mdr", b_bus, 32'h0);
    b_sel = 4'd4;
    #1;
    check_output("rst_sp", b_bus, 32'h0000_0100);
    check_output("rst_n_flag", 32'(n_flag), 32'd0);
    check_output("rst_z_flag", 32'(z_flag), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_mem_req", 32'(mem_req), 32'd0);
    check_output("rst_ftc_req", 32'(ftc_req), 32'd0);
    b_sel = 4'd0;
    step();
    step();
    rst_n = 1'b1;
    check_en = 1'b1;

    // Shifter and flags
    alu_y = 32'h8000_0001; shift = 2'd1; c_sel = 9'h100;
    step();
    check_output("sra1", a_bus, 32'hC000_0000);
    shift = 2'd2; alu_n = 1'b1; alu_z = 1'b0;
    step();
    check_output("sll8", a_bus, 32'h0000_0100);
    check_output("flag_n", 32'(n_flag), 32'd1);
    check_output("flag_z", 32'(z_flag), 32'd0);

    // Write all nine registers at once
    alu_n = 1'b0; alu_z = 1'b1; shift = 2'd0; alu_y = 32'h1234_5678; c_sel = 9'h1FF;
    step();
    c_sel = 9'd0;
    check_output("all_h", a_bus, 32'h1234_5678);
    for (int i = 0; i < 7; i++) begin
      b_sel = all_sels[i];
      #1;
      check_output("all_b", b_bus, 32'h1234_5678);
    end
    b_sel = 4'd9;
    #1;
    check_output("b_sel9_zero", b_bus, 32'h0);
    b_sel = 4'd0;

    // Word read, ack three cycles after the request, with a C write to MDR|H on the ack edge
    alu_y = 32'd5; c_sel = 9'h001;
    step();
    c_sel = 9'd0; rd = 1'b1;
    step();
    rd = 1'b0;
    check_output("rd_req", 32'(mem_req), 32'd1);
    check_output("rd_addr", mem_addr, 32'h14);
    check_output("rd_we", 32'(mem_we), 32'd0);
    check_output("rd_busy", 32'(busy), 32'd1);
    step();
    check_output("rd_req2", 32'(mem_req), 32'd1);
    step();
    check_output("rd_req3", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; alu_y = 32'h1234; c_sel = 9'h102;
    step();
    mem_ack = 1'b0; c_sel = 9'd0;
    check_output("rd_req_drop", 32'(mem_req), 32'd0);
    check_output("rd_busy_drop", 32'(busy), 32'd0);
    check_output("rd_mdr", b_bus, 32'hDEAD_BEEF);
    check_output("rd_h_unaffected", a_bus, 32'h1234);

    // rd and wr together: write wins, ack leaves MDR alone
    rd = 1'b1; wr = 1'b1;
    step();
    rd = 1'b0; wr = 1'b0;
    check_output("wr_we", 32'(mem_we), 32'd1);
    check_output("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    check_output("wr_addr", mem_addr, 32'h14);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    step();
    mem_ack = 1'b0;
    check_output("wr_busy", 32'(busy), 32'd0);
    check_output("wr_mdr_kept", b_bus, 32'hDEAD_BEEF);

    // Read ack colliding with a C write to MDR
    rd = 1'b1;
    step();
    rd = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h55; alu_y = 32'h1234; c_sel = 9'h002;
    step();
    mem_ack = 1'b0; c_sel = 9'd0;
    check_output("collide_mdr", b_bus, 32'h55);

    // Byte fetch with sign/zero extension
    alu_y = 32'd7; c_sel = 9'h004;
    step();
    c_sel = 9'd0; fetch = 1'b1;
    step();
    fetch = 1'b0;
    check_output("ftc_req", 32'(ftc_req), 32'd1);
    check_output("ftc_addr", ftc_addr, 32'd7);
    check_output("ftc_busy", 32'(busy), 32'd1);
    ftc_ack = 1'b1; ftc_rdata = 8'h80;
    step();
    ftc_ack = 1'b0;
    check_output("ftc_req_drop", 32'(ftc_req), 32'd0);
    b_sel = 4'd2;
    #1;
    check_output("mbr_sext", b_bus, 32'hFFFF_FF80);
    b_sel = 4'd3;
    #1;
    check_output("mbr_zext", b_bus, 32'h0000_0080);
    b_sel = 4'd0;

    // Reset asserted while a read is pending
    rd = 1'b1;
    step();
    rd = 1'b0;
    check_output("prerst_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_req", 32'(mem_req), 32'd0);
    check_output("async_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h0000_ABCD;
    step();
    mem_ack = 1'b0;
    check_output("late_ack_mdr", b_bus, 32'h0);
    check_output("late_ack_busy", 32'(busy), 32'd0);

    // Randomized traffic with occasional asynchronous reset pulses
    for (int k = 0; k < 1500; k++) begin
      apply_stimulus();
      step();
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    clear_inputs();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
